exec_result_fifo: RTL and testbench
===================================

Name: exec_result_fifo

Overview:
- Decoupling buffer directly downstream of an issue queue / execute pipe (e.g. the ALU IQ).
- Accepts one `cdb_info_t` result per cycle through a valid/ready handshake; the producer's `fifo_ready` is driven by `in_ready_o`.
- Holds results in order until the CDB arbiter accepts them.
- Supports pipeline flush and exposes occupancy to the arbiter for priority decisions.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; discards all entries.
- in_valid_i  input  1  producer has a result this cycle.
- in_data_i  input  $bits(cdb_info_t)  result payload (cdb_info_t).
- in_ready_o  output  1  FIFO can accept (not full); feeds producer fifo_ready.
- out_valid_o  output  1  head entry is valid.
- out_data_o  output  $bits(cdb_info_t)  head payload (cdb_info_t).
- out_ready_i  input  1  CDB arbiter accepts head this cycle.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.

Behaviour:
- Reset: `rst_n` low asynchronously clears wr_ptr, rd_ptr and count to 0, and clears storage to '0.
  - Outputs under reset: in_ready_o=1, out_valid_o=0, out_data_o='0, count_o=0, full_o=0, empty_o=1.
- Push and pop:
  - push = in_valid_i & in_ready_o & ~flush; pop = out_valid_o & out_ready_i & ~flush.
  - Push writes `mem[wr_ptr]` at the clock edge; wr_ptr advances modulo DEPTH (wraps DEPTH-1 -> 0).
  - Pop advances rd_ptr modulo DEPTH.
- Output timing:
  - out_data_o = mem[rd_ptr], a combinational read of registered state.
  - out_valid_o = (count != 0) & ~flush.
- Latency: a push at edge N makes the entry visible at out_valid_o/out_data_o after edge N, i.e. 1 cycle; there is no same-cycle pass-through in the base build.
- count: next = count + push - pop. `CNT_W` bits; must never exceed DEPTH or go below 0.
- Ready path: in_ready_o = (count != DEPTH). It depends only on registered state, never combinationally on in_valid_i or out_ready_i.
- Full with pop in the same cycle: in_ready_o stays 0. The freed slot becomes available the next cycle; there is no push-through-full.
- Empty with in_valid_i: entry is written; out_valid_o stays 0 this cycle.
- Simultaneous push and pop with 0 < count < DEPTH: both occur; count is unchanged; ordering is preserved.
- Flush: takes priority over push and pop. At the next edge, pointers and count are set to 0; storage is not cleared.
  - During the flush cycle out_valid_o is forced to 0, so the arbiter sees nothing. in_ready_o follows count as normal, but no write occurs.
- Reset asserted mid-operation: all state is lost immediately. Outputs take reset values asynchronously.
- Payload is not inspected or modified. Entries with r_valid=0 are buffered like any other entry.

Optional Feature:
- Macro: EXEC_FIFO_BYPASS_EN.
- Defined:
  - When count==0, in_valid_i=1 and flush=0: out_valid_o=1 and out_data_o=in_data_i combinationally in the same cycle.
  - If out_ready_i=1 in that cycle, the entry is consumed with no write and no count change (0-cycle latency).
  - If out_ready_i=0, the entry is written normally.
- Undefined: behaviour exactly as described above, with 1-cycle minimum latency.

Test Plan:
- Reset then idle → in_ready_o=1, out_valid_o=0, count_o=0, empty_o=1; out_data_o='0.
- Push results with rob_id 1,2,3,4 on consecutive cycles, out_ready_i=0 → count_o=4, full_o=1, in_ready_o=0; a 5th in_valid_i is ignored.
- From full, out_ready_i=1 for 4 cycles → heads pop in order 1,2,3,4, then empty_o=1; in_ready_o=1 one cycle after the first pop.
- Continuous push and pop, 10 entries (rob_id 0..9), out_ready_i=1 → each appears one cycle after its push, in order; count_o stays 1; pointers wrap twice.
- Count 3, assert flush with in_valid_i=1 and out_ready_i=1 → out_valid_o=0 that cycle; next cycle count_o=0 and empty_o=1; the flushed-cycle input is not stored.
- EXEC_FIFO_BYPASS_EN, empty, in_valid_i=1 (rob_id 7), out_ready_i=1 → out_valid_o=1 with rob_id 7 the same cycle; count_o stays 0.

Source files
------------

// File: rtl/exec_result_fifo.sv
// In-order result buffer between an execute pipe and the CDB arbiter.
// Optional same-cycle bypass when empty: define EXEC_FIFO_BYPASS_EN.

package exec_result_fifo_pkg;
  typedef struct packed {
    logic        r_valid;
    logic [4:0]  rob_id;
    logic [31:0] value;
    logic        exc;
  } cdb_info_t;

  localparam int unsigned CDB_W = $bits(cdb_info_t);
endpackage

module exec_result_fifo
  import exec_result_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid_i,
  input  logic [CDB_W-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [CDB_W-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CDB_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             not_empty;
  logic             push;
  logic             pop;

  assign not_empty  = (count != '0);
  assign full_o     = (count == CNT_W'(DEPTH));
  assign empty_o    = ~not_empty;
  assign in_ready_o = ~full_o;
  assign count_o    = count;

`ifdef EXEC_FIFO_BYPASS_EN
  logic bypass;

  // Empty buffer hands the incoming result straight to the arbiter.
  assign bypass      = ~not_empty & in_valid_i & ~flush;
  assign out_valid_o = (not_empty | bypass) & ~flush;
  assign out_data_o  = bypass ? in_data_i : mem[rd_ptr];
  assign push        = in_valid_i & in_ready_o & ~flush & ~(bypass & out_ready_i);
  assign pop         = not_empty & out_ready_i & ~flush;
`else
  assign out_valid_o = not_empty & ~flush;
  assign out_data_o  = mem[rd_ptr];
  assign push        = in_valid_i & in_ready_o & ~flush;
  assign pop         = out_valid_o & out_ready_i & ~flush;
`endif

  // Pointers and occupancy; flush resets bookkeeping but leaves storage intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_exec_result_fifo.sv
// Directed self-checking bench for exec_result_fifo (default depth 4).
// Expectations track EXEC_FIFO_BYPASS_EN when the bench is built with it.

module tb_exec_result_fifo;
  import exec_result_fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid_i;
  logic [CDB_W-1:0] in_data_i;
  logic             in_ready_o;
  logic             out_valid_o;
  logic [CDB_W-1:0] out_data_o;
  logic             out_ready_i;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  exec_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready_i),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  always #5 clk = ~clk;

  function automatic logic [CDB_W-1:0] mk(input int rob);
    cdb_info_t c;
    c.r_valid = 1'b1;
    c.rob_id  = 5'(rob);
    c.value   = 32'hA000 + 32'(rob);
    c.exc     = 1'b0;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks run 1 time unit later.
  task automatic drive(input logic v, input logic [CDB_W-1:0] d, input logic r, input logic f);
    @(negedge clk);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush       = f;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_out_data", 64'(out_data_o), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("idle_out_valid", 64'(out_valid_o), 64'd0);
    chk("idle_count", 64'(count_o), 64'd0);

    // Fill with rob 1..4, arbiter stalled.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, mk(i), 1'b0, 1'b0);
      if (i == 1) begin
`ifdef EXEC_FIFO_BYPASS_EN
        chk("fill_first_bypass_valid", 64'(out_valid_o), 64'd1);
`else
        chk("fill_first_no_passthru", 64'(out_valid_o), 64'd0);
`endif
      end
    end
    drive(1'b1, mk(5), 1'b0, 1'b0);
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_flag", 64'(full_o), 64'd1);
    chk("full_in_ready", 64'(in_ready_o), 64'd0);
    chk("full_head", 64'(out_data_o), 64'(mk(1)));
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("full_5th_ignored", 64'(count_o), 64'd4);

    // Drain in order 1..4.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("drain_valid_%0d", k), 64'(out_valid_o), 64'd1);
      chk($sformatf("drain_head_%0d", k), 64'(out_data_o), 64'(mk(k)));
      if (k == 1) chk("drain_ready_full", 64'(in_ready_o), 64'd0);
      if (k == 2) chk("drain_ready_after_pop", 64'(in_ready_o), 64'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", 64'(empty_o), 64'd1);
    chk("drain_out_valid", 64'(out_valid_o), 64'd0);

    // Streaming: rob 0..9 with the arbiter always ready; pointers wrap twice.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(i), 1'b1, 1'b0);
`ifdef EXEC_FIFO_BYPASS_EN
      chk($sformatf("stream_byp_valid_%0d", i), 64'(out_valid_o), 64'd1);
      chk($sformatf("stream_byp_data_%0d", i), 64'(out_data_o), 64'(mk(i)));
      chk($sformatf("stream_byp_count_%0d", i), 64'(count_o), 64'd0);
`else
      if (i == 0) begin
        chk("stream_first_valid", 64'(out_valid_o), 64'd0);
      end else begin
        chk($sformatf("stream_valid_%0d", i), 64'(out_valid_o), 64'd1);
        chk($sformatf("stream_head_%0d", i), 64'(out_data_o), 64'(mk(i - 1)));
        chk($sformatf("stream_count_%0d", i), 64'(count_o), 64'd1);
      end
`endif
    end
    drive(1'b0, '0, 1'b1, 1'b0);
`ifndef EXEC_FIFO_BYPASS_EN
    chk("stream_last_head", 64'(out_data_o), 64'(mk(9)));
    drive(1'b0, '0, 1'b0, 1'b0);
`endif
    chk("stream_empty", 64'(empty_o), 64'd1);

    // Flush with count 3, concurrent push and pop request.
    for (int i = 20; i <= 22; i++) drive(1'b1, mk(i), 1'b0, 1'b0);
    drive(1'b1, mk(23), 1'b1, 1'b1);
    chk("flush_pre_count", 64'(count_o), 64'd3);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready", 64'(in_ready_o), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);
    chk("flush_out_valid_after", 64'(out_valid_o), 64'd0);
    drive(1'b1, mk(24), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_count", 64'(count_o), 64'd1);
    chk("post_flush_head", 64'(out_data_o), 64'(mk(24)));
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_drained", 64'(empty_o), 64'd1);

    // Empty, in_valid with arbiter ready.
    drive(1'b1, mk(7), 1'b1, 1'b0);
`ifdef EXEC_FIFO_BYPASS_EN
    chk("bypass_valid", 64'(out_valid_o), 64'd1);
    chk("bypass_data", 64'(out_data_o), 64'(mk(7)));
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("bypass_count", 64'(count_o), 64'd0);
`else
    chk("empty_push_valid", 64'(out_valid_o), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("empty_push_count", 64'(count_o), 64'd1);
    chk("empty_push_head", 64'(out_data_o), 64'(mk(7)));
`endif

    // Asynchronous reset in mid-operation.
    drive(1'b1, mk(8), 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count_o), 64'd0);
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_data", 64'(out_data_o), 64'd0);
    chk("async_rst_ready", 64'(in_ready_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
